io_bus_arbiter: RTL

//  Shares the single io-register access port (addr/data_in/data_out/read/write/width) between NREQ requesters
//  (requester 0 = CPU, 1 = DMA, others spare). Serialises accesses as fixed 3-cycle transactions.

---
 rtl/io_bus_pkg.sv | 25 ++
 rtl/io_bus_arbiter_rr_pick.sv | 33 +++
 rtl/io_bus_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the io-register bus arbiter.
// Imported by the arbiter top and its grant picker.
package io_bus_pkg;

    localparam int IO_ADDR_W = 24;
    localparam int IO_DATA_W = 32;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [1:0]           width;
        logic [IO_ADDR_W-1:0] addr;
        logic [IO_DATA_W-1:0] wdata;
    } payload_t;

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational grant picker: round-robin from ptr+1, or fixed
// lowest-index priority when FIXED_PRIO is set.
module rr_pick #(
    parameter int NREQ       = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (FIXED_PRIO != 0) ? i : (int'(ptr) + 1 + i) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Serialises NREQ requesters onto the single io-register port as
// fixed 3-cycle IDLE/XFER/RESP transactions, with optional bus lock.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_LOCK   = 16
) (
    input  logic                      clk_mem,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ-1:0]           we,
    input  logic [2*NREQ-1:0]         width,
    input  logic [IO_ADDR_W*NREQ-1:0] addr,
    input  logic [IO_DATA_W*NREQ-1:0] wdata,
    output logic [NREQ-1:0]           ack,
    output logic [IO_DATA_W-1:0]      rdata,
    output logic [IO_ADDR_W-1:0]      io_addr,
    output logic [IO_DATA_W-1:0]      io_data_in,
    input  logic [IO_DATA_W-1:0]      io_data_out,
    output logic                      io_read,
    output logic                      io_write,
    output logic [1:0]                io_width,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK) + 1;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_l;
    logic            lock_vld;
    logic [IW-1:0]   lock_idx;
    logic [CW-1:0]   lock_cnt;

    logic [NREQ-1:0] own_mask;
    logic            own_live;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    payload_t        pl;
    int              p;

    // A lock whose owner has gone quiet no longer filters the others.
    always_comb begin
        own_mask = NREQ'(1) << lock_idx;
        own_live = lock_vld && req[lock_idx];
        elig     = own_live ? (req & own_mask) : req;
    end

    rr_pick #(
        .NREQ       (NREQ),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        p        = int'(pick_idx);
        pl.we    = we[p];
        pl.width = width[2*p +: 2];
        pl.addr  = addr[IO_ADDR_W*p +: IO_ADDR_W];
        pl.wdata = wdata[IO_DATA_W*p +: IO_DATA_W];
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ack        <= '0;
            rdata      <= '0;
            io_addr    <= '0;
            io_data_in <= '0;
            io_width   <= '0;
            io_read    <= 1'b0;
            io_write   <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= IW'(NREQ - 1);
            gnt_idx    <= '0;
            gnt_l      <= '0;
            lock_vld   <= 1'b0;
            lock_idx   <= '0;
            lock_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lock_vld && !own_live) begin
                        lock_vld <= 1'b0;
                        lock_cnt <= '0;
                    end
                    if (pick_any) begin
                        gnt_idx    <= pick_idx;
                        gnt_l      <= pick_gnt;
                        io_addr    <= pl.addr;
                        io_data_in <= pl.wdata;
                        io_width   <= pl.width;
                        io_write   <= pl.we;
                        io_read    <= ~pl.we;
                        busy       <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (io_read)
                        rdata <= io_data_out;
                    io_read  <= 1'b0;
                    io_write <= 1'b0;
                    ack      <= gnt_l;
                    state    <= RESP;
                end
                RESP: begin
                    ack    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= gnt_idx;
                    if (lock[gnt_idx] && lock_cnt < CW'(MAX_LOCK - 1)) begin
                        lock_vld <= 1'b1;
                        lock_idx <= gnt_idx;
                        lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        lock_vld <= 1'b0;
                        lock_cnt <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
